// File: rtl/gate_bist_pkg.sv
// Shared types and sizing constants for the two-input gate BIST controller.
package gate_bist_pkg;

  localparam int unsigned VEC_N    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned ERR_W    = 8;
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned LOOP_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_bist_timer.sv
// Settle down-counter: loaded on entry to SETTLE, expires when it reaches zero.
module gate_bist_timer
  import gate_bist_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  input  logic                count_i,
  output logic                expire_c
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - SETTLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Exhaustive truth-table BIST for a two-input gate: drives a/b, waits SETTLE
// cycles per vector, compares against a latched truth table, reports results.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned LOOPS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [VEC_N-1:0] truth,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [VEC_N-1:0] fail_mask,
  output logic [ERR_W-1:0] err_count
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LOOP_W-1:0]   loop_q, loop_d, loop_inc;
  logic [VEC_N-1:0]    truth_q, truth_d;
  logic [VEC_N-1:0]    fail_q, fail_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                gate_a_q, gate_a_d;
  logic                gate_b_q, gate_b_d;
  logic                tmr_load, tmr_count, tmr_expire;
  logic                drive_gate;

  gate_bist_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_W'(SETTLE - 1)),
    .count_i    (tmr_count),
    .expire_c   (tmr_expire)
  );

  assign loop_inc = loop_q + LOOP_W'(1);

  // Next state and result bookkeeping; abort wins over every other action.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    loop_d    = loop_q;
    truth_d   = truth_q;
    fail_d    = fail_q;
    err_d     = err_q;
    pass_d    = pass_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_SETTLE;
          truth_d  = truth;
          fail_d   = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          loop_d   = '0;
          tmr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          tmr_count = 1'b1;
          if (tmr_expire) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          if (gate_s != truth_q[idx_q]) begin
            fail_d[idx_q] = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
          end
          idx_d    = idx_q + IDX_W'(1);
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          if (idx_q == IDX_W'(VEC_N - 1)) begin
            loop_d = loop_inc;
            if (loop_inc == LOOP_W'(LOOPS)) begin
              state_d  = ST_DONE;
              tmr_load = 1'b0;
              pass_d   = (fail_d == '0);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) pass_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they align with the state.
  always_comb begin
    drive_gate = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    gate_a_d   = drive_gate & idx_d[0];
    gate_b_d   = drive_gate & idx_d[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      loop_q   <= '0;
      truth_q  <= '0;
      fail_q   <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      loop_q   <= loop_d;
      truth_q  <= truth_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  assign err_count = err_q;

endmodule
